ps2_kbd_ctrl: RTL
=================

# ps2_kbd_ctrl

Scancode-set-2 parser and sequencer that sits between the `ps2_keyboard` receiver FIFO and the keyboard consumer (CPU MMIO register / display logic). It pops bytes from the receiver with a one-cycle read strobe and folds `E0`/`F0`/`E1` prefixes into single key events. Events are presented on a valid/ready port, and the block flags protocol errors and receiver overflow. Optionally, it suppresses typematic repeats using a held-key bitmap.

## Interface
Parameters:
- `TO_W`, default 21: width of the prefix-timeout counter.
- `TO_CYC`, default 21'd1_500_000: cycles allowed between a prefix byte and its follow-up byte (about 30 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `clrn`  in  1  reset; asynchronous and active-low.
- `rx_ready`  in  1  receiver FIFO non-empty; `rx_data` valid.
- `rx_data`  in  8  head byte of receiver FIFO.
- `rx_overflow`  in  1  receiver sticky overflow.
- `rx_pop`  out  1  consume head byte this cycle.
- `ev_valid`  out  1  key event available.
- `ev_ready`  in  1  consumer accepts event.
- `ev_code`  out  8  scancode without prefixes.
- `ev_ext`  out  1  event had `E0` prefix.
- `ev_rel`  out  1  1 = break (release), 0 = make (press).
- `ev_cnt`  out  8  count of accepted events; wraps modulo 256.
- `err`  out  1  sticky protocol/overflow error; cleared only by reset.

## Operation
States:
- `IDLE`
- `EXT` (after `E0`)
- `BRK` (after `F0`)
- `EXT_BRK` (after `E0 F0`)
- `PAUSE` (discarding the `E1` sequence)
- `HOLD` (event pending)

Popping:
- `rx_pop = rx_ready & (state != HOLD)`; this is combinational.
- The byte is consumed on the `clk` edge where `rx_pop = 1`.

Transitions on a consumed byte `b`:
- `IDLE`:
  - `E0` → `EXT`.
  - `F0` → `BRK`.
  - `E1` → `PAUSE`, with the skip counter set to 7.
  - `AA` and `FA` are discarded; state stays `IDLE`.
  - `00` or `FF` → set `err`, stay `IDLE`.
  - Any other byte → emit make event, then `HOLD`.
- `EXT`:
  - `F0` → `EXT_BRK`.
  - `12` (fake shift) → discard, return to `IDLE`.
  - Any other byte → emit ext make, then `HOLD`.
- `BRK` → emit release with `ev_ext = 0`, then `HOLD`.
- `EXT_BRK`:
  - `12` → discard, return to `IDLE`.
  - Any other byte → emit ext release, then `HOLD`.
- `PAUSE`:
  - Decrement the skip counter on each byte.
  - On the 7th byte, emit `ev_code = E1`, `ev_ext = 0`, `ev_rel = 0`, then `HOLD`.
- `HOLD`: when `ev_valid & ev_ready`, increment `ev_cnt` and go to `IDLE`.

Prefix timeout:
- In `EXT`, `BRK`, `EXT_BRK` and `PAUSE`, the timeout counter increments each cycle with no pop and resets on every pop.
- Reaching `TO_CYC` sets `err` and returns to `IDLE`. No event is emitted.

Overflow:
- A rising `rx_overflow` (registered edge detect) sets `err`.
- If the block is not in `HOLD`, it also forces `IDLE`, discarding any partial sequence.
- A pending `HOLD` event is kept.

Simultaneous events: a timeout or overflow abort in the same cycle as a pop takes priority, and that byte is discarded.

## Timing
- Reset values:
  - `ev_valid = 0`, `ev_code = 0`, `ev_ext = 0`, `ev_rel = 0`, `ev_cnt = 0`, `err = 0`.
  - State = `IDLE`, timeout counter = 0, skip counter = 0.
  - The bitmap is all-clear.
  - `rx_pop = 0` during reset.
- Latency: `ev_valid` rises on the edge that consumes the final byte of a sequence and is visible the following cycle.
- `ev_*` fields are stable while `ev_valid = 1`.
- `ev_valid` drops on the edge after the cycle where `ev_ready = 1`.
- No pops occur while in `HOLD`. This gives back-pressure into the receiver FIFO.
- Throughput: at most one byte per cycle, and one event per 2 cycles (`HOLD` → `IDLE` → consume).
- Reset mid-sequence: parsing is abandoned immediately and no event is emitted.

## Configuration
`PS2_REPEAT_FILTER_EN`:
- Defined:
  - A 512-bit held-key bitmap is indexed by `{ext, code}`.
  - Make of an already-set key: the byte is consumed, no event, no `ev_cnt` change, return to `IDLE`.
  - Make of a clear key: the bit is set and the event is emitted.
  - Release always clears the bit and is always emitted, even if the bit was already clear.
  - `E1` is not tracked in the bitmap.
  - Overflow clears the whole bitmap.
- Undefined: no bitmap is built, and every make is emitted.

## Structure
- Package `ps2_kbd_pkg`:
  - State enum.
  - Byte constants `PS2_EXT = 8'hE0`, `PS2_BRK = 8'hF0`, `PS2_PAUSE = 8'hE1`, `PS2_BAT = 8'hAA`, `PS2_ACK = 8'hFA`, `PS2_ERR0 = 8'h00`, `PS2_ERR1 = 8'hFF`, `PS2_FSHIFT = 8'h12`.
  - Skip count `PAUSE_SKIP = 7`.
- Sub-module `ps2_key_bitmap`:
  - Holds the 512-bit register with set/clear/test ports and a clear-all port.
  - Instantiated only under `PS2_REPEAT_FILTER_EN`.

## Test plan
- Bytes `1C`, then `F0 1C`, with `ev_ready = 1` → two events: (`1C`, ext 0, rel 0) then (`1C`, ext 0, rel 1); `ev_cnt = 2`.
- `E0 75`, then `E0 F0 75` → events (`75`, ext 1, rel 0) and (`75`, ext 1, rel 1); `E0 12` produces no event.
- `1C` with `ev_ready = 0` for 20 cycles while 3 more bytes wait → `rx_pop` stays 0 and the `ev_*` fields are stable; on ready, all bytes drain in order.
- `E0` followed by no byte for `TO_CYC` cycles → `err = 1`, state `IDLE`; a following `29` emits (`29`, ext 0, rel 0).
- With `PS2_REPEAT_FILTER_EN`: `1C 1C 1C F0 1C` → exactly 2 events and `ev_cnt = 2`; without the macro → 4 events.
- Full `E1 14 77 E1 F0 14 F0 77` → one event with `ev_code = E1`; `rx_overflow` pulse mid-`F0` → `err = 1` and no release event.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// Shared types and scancode-set-2 byte constants for the PS/2 keyboard parser.
package ps2_kbd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause,
    StHold
  } state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [7:0] PS2_FSHIFT = 8'h12;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/ps2_key_bitmap.sv
// 512-entry held-key bitmap indexed by {ext, code}; used by the typematic repeat filter.
module ps2_key_bitmap (
  input  logic       clk,
  input  logic       clrn,
  input  logic [8:0] idx,
  input  logic       set,
  input  logic       clr,
  input  logic       clr_all,
  output logic       hit
);

  logic [511:0] bits_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bits_q <= '0;
    end else if (clr_all) begin
      bits_q <= '0;
    end else if (set) begin
      bits_q[idx] <= 1'b1;
    end else if (clr) begin
      bits_q[idx] <= 1'b0;
    end
  end

  assign hit = bits_q[idx];

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// Scancode-set-2 prefix folder between the PS/2 receiver FIFO and a valid/ready event port.
// Define PS2_REPEAT_FILTER_EN to drop typematic repeats of already-held keys.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned     TO_W   = 21,
  parameter logic [TO_W-1:0] TO_CYC = 21'd1_500_000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_overflow,
  output logic       rx_pop,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic [7:0] ev_cnt,
  output logic       err
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [2:0]      skip_q, skip_d;
  logic [7:0]      code_q, code_d;
  logic            ext_q, ext_d;
  logic            rel_q, rel_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            ovf_q;
  logic            run_q;

  logic       pop, ovf_rise, in_prefix, timeout, abort;
  logic       emit, emit_ext, emit_rel;
  logic [7:0] emit_code;

  // run_q keeps rx_pop low while reset is asserted even though the state is already Idle.
  assign pop       = rx_ready & run_q & (state_q != StHold);
  assign rx_pop    = pop;
  assign ovf_rise  = rx_overflow & ~ovf_q;
  assign in_prefix = (state_q == StExt) || (state_q == StBrk) ||
                     (state_q == StExtBrk) || (state_q == StPause);
  assign timeout   = in_prefix && (to_q == TO_CYC);
  assign abort     = timeout | (ovf_rise & (state_q != StHold));

`ifdef PS2_REPEAT_FILTER_EN
  logic bm_hit, bm_set, bm_clr, bm_ext;

  assign bm_ext = (state_q == StExt) || (state_q == StExtBrk);

  ps2_key_bitmap u_key_bitmap (
    .clk     (clk),
    .clrn    (clrn),
    .idx     ({bm_ext, rx_data}),
    .set     (bm_set),
    .clr     (bm_clr),
    .clr_all (ovf_rise),
    .hit     (bm_hit)
  );
`endif

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    code_d    = code_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    cnt_d     = cnt_q;
    err_d     = err_q | ovf_rise;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_rel  = 1'b0;
    emit_code = rx_data;
`ifdef PS2_REPEAT_FILTER_EN
    bm_set    = 1'b0;
    bm_clr    = 1'b0;
`endif

    if (!in_prefix || pop) begin
      to_d = '0;
    end else begin
      to_d = to_q + TO_W'(1);
    end

    if (abort) begin
      // The byte popped in this cycle, if any, is dropped with the partial sequence.
      state_d = StIdle;
      err_d   = 1'b1;
    end else if (state_q == StHold) begin
      if (ev_ready) begin
        cnt_d   = cnt_q + 8'd1;
        state_d = StIdle;
      end
    end else if (pop) begin
      unique case (state_q)
        StIdle: begin
          case (rx_data)
            PS2_EXT:            state_d = StExt;
            PS2_BRK:            state_d = StBrk;
            PS2_PAUSE: begin
              state_d = StPause;
              skip_d  = PAUSE_SKIP;
            end
            PS2_BAT, PS2_ACK:   state_d = StIdle;
            PS2_ERR0, PS2_ERR1: err_d   = 1'b1;
            default:            emit    = 1'b1;
          endcase
        end
        StExt: begin
          if (rx_data == PS2_BRK) begin
            state_d = StExtBrk;
          end else if (rx_data == PS2_FSHIFT) begin
            state_d = StIdle;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        StBrk: begin
          emit     = 1'b1;
          emit_rel = 1'b1;
        end
        StExtBrk: begin
          if (rx_data == PS2_FSHIFT) begin
            state_d = StIdle;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
          end
        end
        StPause: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            emit      = 1'b1;
            emit_code = PS2_PAUSE;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (emit) begin
      state_d = StHold;
      code_d  = emit_code;
      ext_d   = emit_ext;
      rel_d   = emit_rel;
`ifdef PS2_REPEAT_FILTER_EN
      // Pause is never tracked; a make of a key already held is a typematic repeat.
      if (state_q != StPause) begin
        if (emit_rel) begin
          bm_clr = 1'b1;
        end else if (bm_hit) begin
          state_d = StIdle;
          code_d  = code_q;
          ext_d   = ext_q;
          rel_d   = rel_q;
        end else begin
          bm_set = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      to_q    <= '0;
      skip_q  <= '0;
      code_q  <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      skip_q  <= skip_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ovf_q   <= rx_overflow;
      run_q   <= 1'b1;
    end
  end

  assign ev_valid = (state_q == StHold);
  assign ev_code  = code_q;
  assign ev_ext   = ext_q;
  assign ev_rel   = rel_q;
  assign ev_cnt   = cnt_q;
  assign err      = err_q;

endmodule
